mc_ssram_resp: RTL and testbench



---
 rtl/mc_ssram_resp.sv | 135 +++++++++++++
 tb/tb_mc_ssram_resp.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ssram_resp.sv
// Synchronous-burst SSRAM responder for the memory controller pin interface.
// Optional per-lane read parity checker: define MC_SSRAM_PARITY_EN.
module mc_ssram_resp #(
    parameter int AW     = 8,
    parameter int CS_BIT = 0
) (
    input  logic        mc_clk,
    input  logic        rst,
    input  logic [23:0] mc_addr,
    input  logic [31:0] mc_data_o,
    input  logic [3:0]  mc_dp_o,
    input  logic        mc_data_oe,
    input  logic [3:0]  mc_dqm,
    input  logic        mc_oe_,
    input  logic        mc_we_,
    input  logic [7:0]  mc_cs_,
    input  logic        mc_adsc_,
    input  logic        mc_adv_,
    input  logic        mc_zz_o,
    output logic [31:0] mc_data_i,
    output logic [3:0]  mc_dp_i,
    output logic        mc_data_drv,
    output logic        mc_ack,
    output logic        mc_sts_i
);
    localparam int DEPTH = 1 << AW;

    logic [31:0]   mem_data [DEPTH];
    logic [3:0]    mem_par  [DEPTH];

    logic          sel;
    logic          ld;
    logic          adv;
    logic          acc;
    logic          wr;
    logic          rd;
    logic          s2_ld;
    logic          par_err;
    logic [AW-1:0] acc_addr;
    logic [AW-1:0] baddr_q;
    logic [AW-1:0] baddr_d;
    logic          burst_vld_q;
    logic          burst_vld_d;
    logic          wr_ack_q;
    logic          rd_s1_q;
    logic          rd_s2_q;
    logic          drv_q;
    logic          sts_q;
    logic [31:0]   s1_data_q;
    logic [3:0]    s1_par_q;
    logic [31:0]   data_q;
    logic [3:0]    par_q;
    logic          unused_ok;

    assign unused_ok = ^{mc_addr, mc_cs_};

    // Burst advance wraps linearly inside the aligned 4-word block.
    always_comb begin
        sel         = !mc_cs_[CS_BIT] && !mc_zz_o;
        ld          = sel && !mc_adsc_;
        adv         = sel && mc_adsc_ && !mc_adv_ && burst_vld_q;
        acc         = ld || adv;
        acc_addr    = ld ? mc_addr[AW-1:0]
                         : {baddr_q[AW-1:2], baddr_q[1:0] + 2'd1};
        wr          = acc && !mc_we_ && mc_data_oe;
        rd          = acc && mc_we_;
        baddr_d     = acc ? acc_addr : baddr_q;
        burst_vld_d = mc_zz_o ? 1'b0 : (burst_vld_q || ld);
        s2_ld       = rd_s1_q && !mc_zz_o;
    end

`ifdef MC_SSRAM_PARITY_EN
    always_comb begin
        par_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((^s1_data_q[8*i +: 8]) != s1_par_q[i]) begin
                par_err = 1'b1;
            end
        end
    end
`else
    assign par_err = 1'b0;
`endif

    always_ff @(posedge mc_clk) begin
        if (wr) begin
            for (int i = 0; i < 4; i++) begin
                if (!mc_dqm[i]) begin
                    mem_data[acc_addr][8*i +: 8] <= mc_data_o[8*i +: 8];
                    mem_par[acc_addr][i]         <= mc_dp_o[i];
                end
            end
        end
    end

    always_ff @(posedge mc_clk) begin
        if (rst) begin
            baddr_q     <= '0;
            burst_vld_q <= 1'b0;
            wr_ack_q    <= 1'b0;
            rd_s1_q     <= 1'b0;
            rd_s2_q     <= 1'b0;
            drv_q       <= 1'b0;
            sts_q       <= 1'b0;
            s1_data_q   <= '0;
            s1_par_q    <= '0;
            data_q      <= '0;
            par_q       <= '0;
        end else begin
            baddr_q     <= baddr_d;
            burst_vld_q <= burst_vld_d;
            wr_ack_q    <= wr;
            rd_s1_q     <= rd;
            rd_s2_q     <= s2_ld;
            drv_q       <= s2_ld && !mc_oe_;
            sts_q       <= s2_ld && par_err;
            // Array is read after any earlier write has landed.
            if (rd) begin
                s1_data_q <= mem_data[acc_addr];
                s1_par_q  <= mem_par[acc_addr];
            end
            if (s2_ld) begin
                data_q <= s1_data_q;
                par_q  <= s1_par_q;
            end
        end
    end

    assign mc_data_i   = data_q;
    assign mc_dp_i     = par_q;
    assign mc_data_drv = drv_q;
    assign mc_ack      = wr_ack_q || rd_s2_q;
    assign mc_sts_i    = sts_q;

endmodule

// File: tb/tb_mc_ssram_resp.sv
// Directed bench for mc_ssram_resp with a queue-based reference model.
module tb_mc_ssram_resp;
    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] mc_addr;
    logic [31:0] mc_data_o;
    logic [3:0]  mc_dp_o;
    logic        mc_data_oe;
    logic [3:0]  mc_dqm;
    logic        mc_oe_;
    logic        mc_we_;
    logic [7:0]  mc_cs_;
    logic        mc_adsc_;
    logic        mc_adv_;
    logic        mc_zz_o;
    logic [31:0] mc_data_i;
    logic [3:0]  mc_dp_i;
    logic        mc_data_drv;
    logic        mc_ack;
    logic        mc_sts_i;

    mc_ssram_resp #(.AW(8), .CS_BIT(0)) dut (
        .mc_clk(clk), .rst(rst), .mc_addr(mc_addr),
        .mc_data_o(mc_data_o), .mc_dp_o(mc_dp_o),
        .mc_data_oe(mc_data_oe), .mc_dqm(mc_dqm),
        .mc_oe_(mc_oe_), .mc_we_(mc_we_), .mc_cs_(mc_cs_),
        .mc_adsc_(mc_adsc_), .mc_adv_(mc_adv_), .mc_zz_o(mc_zz_o),
        .mc_data_i(mc_data_i), .mc_dp_i(mc_dp_i),
        .mc_data_drv(mc_data_drv), .mc_ack(mc_ack),
        .mc_sts_i(mc_sts_i)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Reference model: memory image plus a queue of reads in flight.
    typedef struct {
        int          due;
        logic [31:0] d;
        logic [3:0]  p;
        bit          s;
    } rd_t;

    logic [31:0] mmem [256];
    logic [3:0]  mdp  [256];
    rd_t         rq[$];
    logic [7:0]  mbaddr = '0;
    bit          mburst = 0;
    bit          armed  = 0;
    int          cyc    = 0;
    logic        e_ack, e_drv, e_sts;
    logic [31:0] e_data;
    logic [3:0]  e_dp;

    function automatic bit perr(input logic [31:0] d, input logic [3:0] p);
`ifdef MC_SSRAM_PARITY_EN
        for (int i = 0; i < 4; i++)
            if ((^d[8*i +: 8]) != p[i]) return 1'b1;
`endif
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        logic [7:0] a;
        bit         acc;
        rd_t        r;
        cyc++;
        acc = 0;
        a   = '0;
        if (rst) begin
            rq.delete();
            mburst = 0;
            armed  = 1;
            e_ack  = 0; e_drv = 0; e_sts = 0;
            e_data = '0; e_dp = '0;
        end else if (mc_zz_o) begin
            rq.delete();
            mburst = 0;
            e_ack  = 0; e_drv = 0; e_sts = 0;
        end else begin
            e_ack = 0; e_drv = 0; e_sts = 0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                r      = rq.pop_front();
                e_ack  = 1;
                e_drv  = !mc_oe_;
                e_sts  = r.s;
                e_data = r.d;
                e_dp   = r.p;
            end
            if (!mc_cs_[0]) begin
                if (!mc_adsc_) begin
                    a = mc_addr[7:0]; acc = 1; mburst = 1;
                end else if (!mc_adv_ && mburst) begin
                    a = {mbaddr[7:2], mbaddr[1:0] + 2'd1}; acc = 1;
                end
            end
            if (acc) begin
                mbaddr = a;
                if (mc_we_) begin
                    r.due = cyc + 1;
                    r.d   = mmem[a];
                    r.p   = mdp[a];
                    r.s   = perr(mmem[a], mdp[a]);
                    rq.push_back(r);
                end else if (mc_data_oe) begin
                    for (int i = 0; i < 4; i++) begin
                        if (!mc_dqm[i]) begin
                            mmem[a][8*i +: 8] = mc_data_o[8*i +: 8];
                            mdp[a][i]         = mc_dp_o[i];
                        end
                    end
                    e_ack = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("m_ack", mc_ack, e_ack);
            chk("m_drv", mc_data_drv, e_drv);
            chk("m_sts", mc_sts_i, e_sts);
            chk("m_data", mc_data_i, e_data);
            chk("m_dp", mc_dp_i, e_dp);
        end
    end

    task automatic idle();
        mc_cs_ = 8'hFF; mc_adsc_ = 1; mc_adv_ = 1; mc_we_ = 1;
        mc_data_oe = 0; mc_dqm = '0; mc_data_o = '0; mc_dp_o = '0;
        mc_addr = '0;
    endtask

    task automatic wr(input logic [23:0] a, input logic [31:0] d,
                      input logic [3:0] p, input logic [3:0] m);
        mc_cs_ = 8'hFE; mc_adsc_ = 0; mc_we_ = 0; mc_data_oe = 1;
        mc_addr = a; mc_data_o = d; mc_dp_o = p; mc_dqm = m;
        @(negedge clk);
        idle();
    endtask

    task automatic rd(input logic [23:0] a);
        mc_cs_ = 8'hFE; mc_adsc_ = 0; mc_we_ = 1; mc_addr = a;
        @(negedge clk);
        idle();
    endtask

    task automatic advs();
        mc_cs_ = 8'hFE; mc_adsc_ = 1; mc_adv_ = 0; mc_we_ = 1;
    endtask

    logic [31:0] seq [4];

    initial begin
        idle();
        rst = 1; mc_oe_ = 0; mc_zz_o = 0;
        repeat (3) @(negedge clk);
        chk("rst_ack", mc_ack, 0);
        chk("rst_data", mc_data_i, 0);
        chk("rst_drv", mc_data_drv, 0);
        rst = 0;
        @(negedge clk);

        wr(24'h000012, 32'hA5A5_5A5A, 4'h5, 4'h0);
        chk("wr_ack", mc_ack, 1);
        @(negedge clk);
        chk("wr_ack_off", mc_ack, 0);
        rd(24'h000012);
        chk("rd_ack_early", mc_ack, 0);
        @(negedge clk);
        chk("rd_data", mc_data_i, 32'hA5A5_5A5A);
        chk("rd_dp", mc_dp_i, 4'h5);
        chk("rd_ack", mc_ack, 1);
        chk("rd_drv", mc_data_drv, 1);

        for (int i = 4; i < 8; i++) wr(24'(i), 32'(i), 4'h0, 4'h0);
        seq = '{32'd6, 32'd7, 32'd4, 32'd5};
        mc_cs_ = 8'hFE; mc_adsc_ = 0; mc_we_ = 1; mc_addr = 24'h000006;
        @(negedge clk);
        advs();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 2) idle();
            chk("burst_data", mc_data_i, seq[i]);
            chk("burst_ack", mc_ack, 1);
        end
        @(negedge clk);

        wr(24'h000020, 32'hFFFF_FFFF, 4'hF, 4'h0);
        wr(24'h000020, 32'h1122_3344, 4'h0, 4'hA);
        rd(24'h000020);
        @(negedge clk);
        chk("mask_data", mc_data_i, 32'hFF22_FF44);
        chk("mask_dp", mc_dp_i, 4'hA);

        mc_cs_ = 8'h01; mc_adsc_ = 0; mc_adv_ = 0; mc_we_ = 0;
        mc_data_oe = 1; mc_addr = 24'h000012; mc_data_o = '0;
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("desel_ack", mc_ack, 0);
        rd(24'h000012);
        @(negedge clk);
        chk("desel_keep", mc_data_i, 32'hA5A5_5A5A);

        rst = 1;
        @(negedge clk);
        rst = 0;
        advs(); mc_we_ = 0; mc_data_oe = 1;
        repeat (2) @(negedge clk);
        idle();
        chk("adv_novld_ack", mc_ack, 0);
        @(negedge clk);

        mc_oe_ = 1;
        rd(24'h000012);
        @(negedge clk);
        chk("oe_ack", mc_ack, 1);
        chk("oe_drv", mc_data_drv, 0);
        chk("oe_data", mc_data_i, 32'hA5A5_5A5A);
        mc_oe_ = 0;

        mc_cs_ = 8'hFE; mc_adsc_ = 0; mc_we_ = 1; mc_addr = 24'h000004;
        @(negedge clk);
        advs();
        @(negedge clk);
        chk("zz_beat0", mc_data_i, 32'd4);
        mc_zz_o = 1;
        @(negedge clk);
        chk("zz_ack", mc_ack, 0);
        chk("zz_drv", mc_data_drv, 0);
        mc_zz_o = 0;
        @(negedge clk);
        chk("zz_ack2", mc_ack, 0);
        idle();
        @(negedge clk);
        chk("zz_adv_ign", mc_ack, 0);
        rd(24'h000004);
        @(negedge clk);
        chk("zz_keep", mc_data_i, 32'd4);

        wr(24'h000030, 32'h0000_0001, 4'h0, 4'h0);
        rd(24'h000030);
        @(negedge clk);
`ifdef MC_SSRAM_PARITY_EN
        chk("par_bad", mc_sts_i, 1);
`else
        chk("par_bad", mc_sts_i, 0);
`endif
        wr(24'h000030, 32'h0000_0001, 4'h1, 4'h0);
        rd(24'h000030);
        @(negedge clk);
        chk("par_ok", mc_sts_i, 0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
